// File: rtl/bcd_gray_pkg.sv
// Shared types, limits and the binary-to-Gray helper for the BCD-to-Gray encoder.
package bcd_gray_pkg;

    typedef enum logic [1:0] {
        S_TENS  = 2'd0,
        S_UNITS = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [7:0] GRAY_MAX  = 8'd15;

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/bcd_gray_if.sv
// Digit-entry stream and Gray result handshake of the BCD-to-Gray encoder.
interface bcd_gray_if;

    logic [3:0] digit_i;
    logic       digit_valid_i;
    logic       digit_ready_o;
    logic [3:0] gray_o;
    logic       gray_valid_o;
    logic       gray_ready_i;
    logic       err_o;

    modport slave (
        input  digit_i, digit_valid_i, gray_ready_i,
        output digit_ready_o, gray_o, gray_valid_o, err_o
    );

    modport master (
        output digit_i, digit_valid_i, gray_ready_i,
        input  digit_ready_o, gray_o, gray_valid_o, err_o
    );

endinterface

// File: rtl/bcd_gray.sv
// Two-digit BCD to 4-bit Gray encoder with range check and registered result handshake.
// Define BCD_GRAY_TIMEOUT_EN to abort a missing units digit after TIMEOUT_CYCLES cycles.
module bcd_gray
    import bcd_gray_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    bcd_gray_if.slave    bus
);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_tens, w_tens_nxt;
    logic       r_bad, w_bad_nxt;
    logic [3:0] r_gray, w_gray_nxt;
    logic       r_err, w_err_nxt;
    logic [7:0] w_value;
    logic       w_units_err;

`ifdef BCD_GRAY_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
`endif

    // Invalid digits can reach 15*10+15 = 165, which still fits in 8 bits.
    assign w_value     = {4'd0, r_tens} * 8'd10 + {4'd0, bus.digit_i};
    assign w_units_err = r_bad | (bus.digit_i > DIGIT_MAX) | (w_value > GRAY_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_tens_nxt  = r_tens;
        w_bad_nxt   = r_bad;
        w_gray_nxt  = r_gray;
        w_err_nxt   = r_err;
`ifdef BCD_GRAY_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
`endif
        unique case (r_state)
            S_TENS: begin
                if (bus.digit_valid_i) begin
                    w_tens_nxt  = bus.digit_i;
                    w_bad_nxt   = bus.digit_i > DIGIT_MAX;
                    w_state_nxt = S_UNITS;
`ifdef BCD_GRAY_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            S_UNITS: begin
                if (bus.digit_valid_i) begin
                    w_err_nxt   = w_units_err;
                    w_gray_nxt  = w_units_err ? 4'd0 : bin2gray(w_value[3:0]);
                    w_state_nxt = S_OUT;
                end
`ifdef BCD_GRAY_TIMEOUT_EN
                else if (r_cnt == CntLast) begin
                    w_err_nxt   = 1'b1;
                    w_gray_nxt  = 4'd0;
                    w_state_nxt = S_OUT;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
`endif
            end
            S_OUT: begin
                if (bus.gray_ready_i) begin
                    w_state_nxt = S_TENS;
                end
            end
            default: w_state_nxt = S_TENS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_TENS;
            r_tens  <= 4'd0;
            r_bad   <= 1'b0;
            r_gray  <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tens  <= w_tens_nxt;
            r_bad   <= w_bad_nxt;
            r_gray  <= w_gray_nxt;
            r_err   <= w_err_nxt;
        end
    end

`ifdef BCD_GRAY_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`endif

    assign bus.digit_ready_o = (r_state != S_OUT);
    assign bus.gray_valid_o  = (r_state == S_OUT);
    assign bus.gray_o        = r_gray;
    assign bus.err_o         = r_err;

endmodule

// File: tb/tb_bcd_gray.sv
// Directed bench for bcd_gray: transaction-level reference model plus literal expectations.
module tb_bcd_gray;

    localparam int unsigned TO = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    bcd_gray_if bus ();

    bcd_gray #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal value from the two digits, range check, then Gray of the value.
    function automatic logic [4:0] model_result(input int t, input int u);
        int v;
        int g;
        v = t * 10 + u;
        if (t > 9 || u > 9 || v > 15) return 5'b1_0000;
        g = v ^ (v / 2);
        return {1'b0, 4'(g)};
    endfunction

    logic       m_units;
    logic       m_pending;
    int         m_tens;
    int         m_cnt;
    logic [3:0] m_gray;
    logic       m_err;

    always @(posedge clk or negedge rst_n) begin
        logic [4:0] r;
        if (!rst_n) begin
            m_units   <= 1'b0;
            m_pending <= 1'b0;
            m_tens    <= 0;
            m_cnt     <= 0;
            m_gray    <= 4'd0;
            m_err     <= 1'b0;
        end else if (m_pending) begin
            if (bus.gray_ready_i) m_pending <= 1'b0;
        end else if (!m_units) begin
            if (bus.digit_valid_i) begin
                m_tens  <= int'(bus.digit_i);
                m_units <= 1'b1;
                m_cnt   <= 0;
            end
        end else if (bus.digit_valid_i) begin
            r = model_result(m_tens, int'(bus.digit_i));
            m_err     <= r[4];
            m_gray    <= r[3:0];
            m_pending <= 1'b1;
            m_units   <= 1'b0;
        end else begin
`ifdef BCD_GRAY_TIMEOUT_EN
            if (m_cnt == int'(TO) - 1) begin
                m_err     <= 1'b1;
                m_gray    <= 4'd0;
                m_pending <= 1'b1;
                m_units   <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready", {3'd0, bus.digit_ready_o}, {3'd0, !m_pending});
            chk("valid", {3'd0, bus.gray_valid_o}, {3'd0, m_pending});
            if (m_pending) begin
                chk("gray", bus.gray_o, m_gray);
                chk("err", {3'd0, bus.err_o}, {3'd0, m_err});
            end
        end
    end

    task automatic xfer(input logic [3:0] t, input logic [3:0] u, input logic [3:0] eg,
                        input logic ee, input int hold, input logic bp);
        bus.digit_valid_i = 1'b1;
        bus.digit_i       = t;
        @(posedge clk); #1;
        bus.digit_i       = u;
        @(posedge clk); #1;
        bus.digit_valid_i = bp;
        bus.digit_i       = 4'd0;
        chk("lit_valid", {3'd0, bus.gray_valid_o}, 4'd1);
        chk("lit_gray", bus.gray_o, eg);
        chk("lit_err", {3'd0, bus.err_o}, {3'd0, ee});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_gray", bus.gray_o, eg);
            chk("hold_ready", {3'd0, bus.digit_ready_o}, 4'd0);
        end
        bus.gray_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.gray_ready_i = 1'b0;
        chk("lit_drop", {3'd0, bus.gray_valid_o}, 4'd0);
    endtask

    initial begin
        n_checks          = 0;
        n_err             = 0;
        rst_n             = 1'b0;
        bus.digit_i       = 4'd0;
        bus.digit_valid_i = 1'b0;
        bus.gray_ready_i  = 1'b0;
        #3;
        chk("rst_valid", {3'd0, bus.gray_valid_o}, 4'd0);
        chk("rst_gray", bus.gray_o, 4'd0);
        chk("rst_err", {3'd0, bus.err_o}, 4'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", {3'd0, bus.digit_ready_o}, 4'd1);

        xfer(4'd1, 4'd2, 4'b1010, 1'b0, 0, 1'b0);
        xfer(4'd0, 4'd7, 4'b0100, 1'b0, 0, 1'b0);
        xfer(4'd1, 4'd0, 4'b1111, 1'b0, 1, 1'b0);
        xfer(4'd0, 4'd0, 4'b0000, 1'b0, 0, 1'b0);
        xfer(4'd1, 4'd5, 4'b1000, 1'b0, 0, 1'b0);
        xfer(4'd1, 4'd6, 4'b0000, 1'b1, 0, 1'b0);
        xfer(4'hA, 4'd0, 4'b0000, 1'b1, 0, 1'b0);
        xfer(4'd0, 4'hC, 4'b0000, 1'b1, 0, 1'b0);
        // Digit 0 stays offered during backpressure; it must become the next tens only.
        xfer(4'd0, 4'd9, 4'b1101, 1'b0, 5, 1'b1);
        xfer(4'd0, 4'd7, 4'b0100, 1'b0, 0, 1'b0);

`ifdef BCD_GRAY_TIMEOUT_EN
        bus.digit_valid_i = 1'b1;
        bus.digit_i       = 4'd1;
        @(posedge clk); #1;
        bus.digit_valid_i = 1'b0;
        repeat (TO - 1) begin
            @(posedge clk); #1;
            chk("to_wait", {3'd0, bus.gray_valid_o}, 4'd0);
        end
        @(posedge clk); #1;
        chk("to_valid", {3'd0, bus.gray_valid_o}, 4'd1);
        chk("to_err", {3'd0, bus.err_o}, 4'd1);
        chk("to_gray", bus.gray_o, 4'd0);
        bus.gray_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.gray_ready_i  = 1'b0;
        bus.digit_valid_i = 1'b1;
        bus.digit_i       = 4'd1;
        @(posedge clk); #1;
        bus.digit_valid_i = 1'b0;
        repeat (TO - 1) @(posedge clk);
        #1;
        bus.digit_valid_i = 1'b1;
        bus.digit_i       = 4'd2;
        @(posedge clk); #1;
        bus.digit_valid_i = 1'b0;
        chk("to_last_valid", {3'd0, bus.gray_valid_o}, 4'd1);
        chk("to_last_err", {3'd0, bus.err_o}, 4'd0);
        chk("to_last_gray", bus.gray_o, 4'b1010);
        bus.gray_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.gray_ready_i = 1'b0;
`endif

        // Leave err_o set, then abort a half-entered value with reset.
        xfer(4'd2, 4'd0, 4'b0000, 1'b1, 0, 1'b0);
        bus.digit_valid_i = 1'b1;
        bus.digit_i       = 4'd1;
        @(posedge clk); #1;
        bus.digit_valid_i = 1'b0;
        rst_n             = 1'b0;
        #1;
        chk("mid_rst_valid", {3'd0, bus.gray_valid_o}, 4'd0);
        chk("mid_rst_gray", bus.gray_o, 4'd0);
        chk("mid_rst_err", {3'd0, bus.err_o}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(4'd0, 4'd7, 4'b0100, 1'b0, 0, 1'b0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
